// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the 8-bit memory/IO bus.
// Supports locked bursts capped at MAX_BURST and suppresses writes to ROM and unmapped space.
module mem_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m0_lock,
  input  logic       m0_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_gnt,
  output logic       m0_rvalid,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_lock,
  input  logic       m1_we,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_gnt,
  output logic       m1_rvalid,
  output logic [7:0] m1_rdata,
  output logic       mem_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out,
  output logic       wr_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t     state, state_next;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       cmd_owner;
  logic       last_grant, lock_active, lock_owner;
  logic [3:0] burst_cnt;

  logic       grant, win;
  logic       win_we, win_lock, other_req;
  logic [7:0] win_addr, win_wdata;
  logic       owner_req, owner_lock, owner_keeps;
  logic       addr_writable;

  assign owner_req     = lock_owner ? m1_req  : m0_req;
  assign owner_lock    = lock_owner ? m1_lock : m0_lock;
  assign owner_keeps   = lock_active && owner_lock && (burst_cnt < 4'(MAX_BURST));
  assign addr_writable = cmd_addr[7] && (cmd_addr[7:4] != 4'hE);

  assign win_we    = win ? m1_we    : m0_we;
  assign win_lock  = win ? m1_lock  : m0_lock;
  assign win_addr  = win ? m1_addr  : m0_addr;
  assign win_wdata = win ? m1_wdata : m0_wdata;
  assign other_req = win ? m0_req   : m1_req;

  assign mem_address = cmd_addr;
  assign mem_data_in = cmd_wdata;

  // An exhausted lock leaves last_grant pointing at the owner, so round-robin hands over.
  always_comb begin : arbitrate
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = 1'b0;
    win   = 1'b0;
    if (state == IDLE) begin
      if (m0_req && m1_req) begin
        grant = 1'b1;
        win   = owner_keeps ? lock_owner : ~last_grant;
      end else if (m0_req) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (m1_req) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin : state_reg
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin : fsm_next
    state_next = state;
    mem_write  = 1'b0;
    wr_err     = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant) state_next = win_we ? WR : RD1;
      end
      WR: begin
        mem_write  = addr_writable;
        wr_err     = !addr_writable;
        state_next = IDLE;
      end
      RD1:     state_next = RD2;
      RD2:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : datapath
    if (!reset) begin
      cmd_addr    <= 8'h00;
      cmd_wdata   <= 8'h00;
      cmd_owner   <= 1'b0;
      last_grant  <= 1'b1;
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      burst_cnt   <= 4'd0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= 8'h00;
      m1_rdata    <= 8'h00;
    end else begin
      m0_gnt    <= grant && !win;
      m1_gnt    <= grant && win;
      m0_rvalid <= (state == RD2) && !cmd_owner;
      m1_rvalid <= (state == RD2) && cmd_owner;

      if (state == RD2) begin
        if (cmd_owner) m1_rdata <= mem_data_out;
        else           m0_rdata <= mem_data_out;
      end

      if (grant) begin
        cmd_addr   <= win_addr;
        cmd_wdata  <= win_wdata;
        cmd_owner  <= win;
        last_grant <= win;
        if (win_lock) begin
          // The burst count only survives a grant to the same owner.
          lock_active <= 1'b1;
          lock_owner  <= win;
          burst_cnt   <= ((lock_active && (lock_owner == win)) ? burst_cnt : 4'd0)
                         + 4'(other_req);
        end else begin
          lock_active <= 1'b0;
          burst_cnt   <= 4'd0;
        end
      end else if ((state == IDLE) && lock_active && !owner_req) begin
        lock_active <= 1'b0;
        burst_cnt   <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: memory model, read-data and grant-order scoreboards.
// Each scenario task drives stimulus and compares inline; a negedge monitor drains the scoreboards.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req = 0, m0_lock = 0, m0_we = 0;
  logic [7:0] m0_addr = 0, m0_wdata = 0;
  logic       m0_gnt, m0_rvalid;
  logic [7:0] m0_rdata;
  logic       m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [7:0] m1_addr = 0, m1_wdata = 0;
  logic       m1_gnt, m1_rvalid;
  logic [7:0] m1_rdata;
  logic       mem_write, wr_err, busy;
  logic [7:0] mem_address, mem_data_in, mem_data_out;

  mem_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, so data follows a held address by one cycle.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    mem_data_out <= mem[mem_address];
    if (mem_write) mem[mem_address] <= mem_data_in;
  end

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rd0 [$];
  logic [7:0] exp_rd1 [$];
  bit         exp_gnt [$];
  bit         gnt_track = 1'b0;
  int         wr_err_seen = 0;
  int         mem_write_seen = 0;
  logic [7:0] exp_v0, exp_v1;
  bit         exp_g;

  always @(negedge clk) begin : monitor
    if (m0_rvalid) begin
      checks++;
      if (exp_rd0.size() == 0) begin
        errors++;
        $display("FAIL m0_rvalid_unexpected: rdata=%h, no read outstanding", m0_rdata);
      end else begin
        exp_v0 = exp_rd0.pop_front();
        if (m0_rdata !== exp_v0) begin
          errors++;
          $display("FAIL m0_rdata: got %h expected %h", m0_rdata, exp_v0);
        end
      end
    end
    if (m1_rvalid) begin
      checks++;
      if (exp_rd1.size() == 0) begin
        errors++;
        $display("FAIL m1_rvalid_unexpected: rdata=%h, no read outstanding", m1_rdata);
      end else begin
        exp_v1 = exp_rd1.pop_front();
        if (m1_rdata !== exp_v1) begin
          errors++;
          $display("FAIL m1_rdata: got %h expected %h", m1_rdata, exp_v1);
        end
      end
    end
    if (gnt_track && (m0_gnt || m1_gnt)) begin
      checks++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: m0_gnt=%b m1_gnt=%b", m0_gnt, m1_gnt);
      end else begin
        exp_g = exp_gnt.pop_front();
        if ((m0_gnt && m1_gnt) || (m1_gnt !== exp_g)) begin
          errors++;
          $display("FAIL grant_order: got m0_gnt=%b m1_gnt=%b expected master %0d", m0_gnt, m1_gnt, exp_g);
        end
      end
    end
    if (wr_err)    wr_err_seen++;
    if (mem_write) mem_write_seen++;
  end

  task automatic drive(input bit m, input bit req, input bit we, input bit lk,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (m) begin
      m1_req = req; m1_we = we; m1_lock = lk; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_lock = lk; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin idle = 1'b1; break; end
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL idle_timeout: busy=%b expected 0", busy); end
  endtask

  // Issues one access from a negedge in IDLE, waits for the grant, drops req, then waits for IDLE.
  task automatic do_access(input bit m, input bit we, input bit lk,
                           input logic [7:0] addr, input logic [7:0] wdata);
    bit got = 1'b0;
    drive(m, 1'b1, we, lk, addr, wdata);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m ? m1_gnt : m0_gnt) === 1'b1) begin got = 1'b1; break; end
    end
    drive(m, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (!got) begin errors++; $display("FAIL gnt_timeout: master %0d got no grant", m); end
    wait_idle();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_write, wr_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_write, wr_err, busy});
    end
    checks++;
    if ({mem_address, mem_data_in, m0_rdata, m1_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 00000000", {mem_address, mem_data_in, m0_rdata, m1_rdata});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rom_read();
    exp_rd0.push_back(init_val(8'h10));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, busy, mem_write, mem_address} !== {4'b1010, 8'h10}) begin
      errors++;
      $display("FAIL rd_cycle1: got gnt0/gnt1/busy/we=%b%b%b%b addr=%h expected 1010 addr=10",
               m0_gnt, m1_gnt, busy, mem_write, mem_address);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({m0_gnt, mem_write, m0_rvalid, mem_address} !== {3'b000, 8'h10}) begin
      errors++;
      $display("FAIL rd_cycle2: got gnt/we/rvalid=%b%b%b addr=%h expected 000 addr=10",
               m0_gnt, mem_write, m0_rvalid, mem_address);
    end
    @(negedge clk);
    checks++;
    if ({m0_rvalid, busy} !== 2'b10) begin
      errors++;
      $display("FAIL rd_cycle3: got rvalid=%b busy=%b expected rvalid=1 busy=0", m0_rvalid, busy);
    end
  endtask

  task automatic test_write_read();
    int we0 = mem_write_seen;
    int er0 = wr_err_seen;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h90, 8'h3C);
    @(negedge clk);
    checks++;
    if ({m1_gnt, mem_write, wr_err, mem_address, mem_data_in} !== {3'b110, 8'h90, 8'h3C}) begin
      errors++;
      $display("FAIL wr_cycle1: got gnt/we/err=%b%b%b addr=%h data=%h expected 110 addr=90 data=3c",
               m1_gnt, mem_write, wr_err, mem_address, mem_data_in);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({mem_write, busy} !== 2'b00) begin
      errors++;
      $display("FAIL wr_cycle2: got we=%b busy=%b expected 00", mem_write, busy);
    end
    exp_rd1.push_back(8'h3C);
    do_access(1'b1, 1'b0, 1'b0, 8'h90, 8'h00);
    @(negedge clk);
    checks++;
    if ((mem_write_seen - we0) !== 1 || (wr_err_seen - er0) !== 0) begin
      errors++;
      $display("FAIL wr_strobe_count: got writes=%0d errs=%0d expected writes=1 errs=0",
               mem_write_seen - we0, wr_err_seen - er0);
    end
  endtask

  task automatic test_bad_write();
    int we0 = mem_write_seen;
    int er0 = wr_err_seen;
    logic [7:0] bad [2];
    bad[0] = 8'h20;
    bad[1] = 8'hE5;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, bad[i], 8'h77);
      @(negedge clk);
      checks++;
      if ({m0_gnt, mem_write, wr_err} !== 3'b101) begin
        errors++;
        $display("FAIL bad_wr_%h: got gnt/we/err=%b%b%b expected 101", bad[i], m0_gnt, mem_write, wr_err);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      wait_idle();
    end
    checks++;
    if ((mem_write_seen - we0) !== 0 || (wr_err_seen - er0) !== 2) begin
      errors++;
      $display("FAIL bad_wr_count: got writes=%0d errs=%0d expected writes=0 errs=2",
               mem_write_seen - we0, wr_err_seen - er0);
    end
    exp_rd0.push_back(init_val(8'h20));
    do_access(1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
  endtask

  // Counts grants while both masters request; drops both requests on the n-th grant.
  task automatic run_contention(input int n);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) seen++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (seen !== n) begin errors++; $display("FAIL contention_timeout: got %0d grants expected %0d", seen, n); end
    wait_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_gnt.size() !== 0) begin
      errors++;
      $display("FAIL grant_sequence_left: got %0d unconsumed expected 0", exp_gnt.size());
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(1'b0);
      exp_gnt.push_back(1'b1);
      exp_rd0.push_back(init_val(8'h11));
      exp_rd1.push_back(init_val(8'h12));
    end
    gnt_track = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
    run_contention(6);
    gnt_track = 1'b0;
  endtask

  task automatic test_lock_burst();
    exp_rd0.push_back(init_val(8'h13));
    do_access(1'b0, 1'b0, 1'b0, 8'h13, 8'h00);
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(1'b1);
      exp_rd1.push_back(init_val(8'h14));
    end
    exp_gnt.push_back(1'b0);
    exp_rd0.push_back(init_val(8'h11));
    gnt_track = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 8'h00);
    run_contention(5);
    gnt_track = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit saw_rvalid = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h16, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_write, wr_err, busy,
         mem_address, mem_data_in, m0_rdata, m1_rdata} !== 39'h0) begin
      errors++;
      $display("FAIL abort_outputs: got flags=%b addr=%h wdata=%h rd0=%h rd1=%h expected all 0",
               {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_write, wr_err, busy},
               mem_address, mem_data_in, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m0_rvalid) saw_rvalid = 1'b1;
    end
    checks++;
    if (saw_rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid: got 1 expected 0"); end
    exp_rd1.push_back(init_val(8'h15));
    do_access(1'b1, 1'b0, 1'b0, 8'h15, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
    test_reset();
    test_rom_read();
    test_write_read();
    test_bad_write();
    test_round_robin();
    test_lock_burst();
    test_reset_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_rd0.size() !== 0 || exp_rd1.size() !== 0) begin
      errors++;
      $display("FAIL reads_outstanding: got m0=%0d m1=%0d expected 0 0", exp_rd0.size(), exp_rd1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and access sequencer for the 8-bit memory/IO subsystem (ROM 0x00-0x7F, RAM 0x80-0xDF, ports 0xF0-0xFF).
- Shares the single memory port between master 0 (CPU) and master 1 (loader/DMA) with round-robin arbitration and optional locked bursts.
- Sequences each access: 1-cycle write, or 2-cycle read with the address held through the data phase.
- Suppresses writes to ROM and to the unmapped range 0xE0-0xEF, and flags them.

Parameters:
- MAX_BURST, 4: maximum consecutive grants to a locking master while the other master is requesting; range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- m0_req  input  1  master 0 access request; held until m0_gnt
- m0_lock  input  1  master 0 requests to keep ownership after this access
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  8  master 0 address
- m0_wdata  input  8  master 0 write data
- m0_gnt  output  1  1-cycle pulse: command accepted and latched
- m0_rvalid  output  1  1-cycle pulse: m0_rdata valid
- m0_rdata  output  8  read data for master 0
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1
- mem_write  output  1  memory write strobe
- mem_address  output  8  memory address
- mem_data_in  output  8  memory write data
- mem_data_out  input  8  memory read data; valid in the cycle after an address is presented, provided the address is held
- wr_err  output  1  1-cycle pulse: write suppressed (ROM or unmapped address)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low. It forces:
  - state to IDLE;
  - every output to 0, including mem_address=0x00 and both rdata=0x00;
  - last_grant=1, so master 0 wins the first tie;
  - burst counter to 0 and lock owner to none.
- Reset during an access aborts it: no write completes, and no rvalid is issued after reset deasserts.
- States are IDLE, WR, RD1 and RD2. Requests are sampled only in IDLE.
- IDLE, at the rising edge:
  - if any request is eligible, select a winner;
  - latch its addr, we and wdata into internal command registers;
  - pulse the winner's gnt for the next cycle;
  - go to WR if we=1, otherwise RD1.
- WR, 1 cycle:
  - mem_address = latched address, mem_data_in = latched data;
  - mem_write = 1 unless the address is below 0x80 or in 0xE0-0xEF; in those cases mem_write = 0 and wr_err pulses in this cycle;
  - next state is IDLE.
- RD1: mem_address = latched address, mem_write = 0; next state is RD2.
- RD2: mem_address held unchanged. At the edge ending RD2, mem_data_out is captured into the owner's rdata. That owner's rvalid is high in the following cycle, which is IDLE. Next state is IDLE.
- Latency, from the edge at which req is sampled in IDLE:
  - gnt in cycle +1;
  - a write completes at the end of cycle +1, and the next sample is at the end of cycle +2;
  - read rvalid is in cycle +3, with arbitration in that same cycle.
- Peak throughput is one write per 2 cycles or one read per 3 cycles.
- Outside WR, RD1 and RD2, mem_address holds its last value and mem_write = 0.
- A master that keeps req asserted after seeing gnt has made a new request, sampled at the next IDLE.
- Round-robin: if both masters request and no lock is active, the master that is not last_grant wins. last_grant updates on every grant.
- Lock:
  - a grant taken with lock=1 makes the winner lock owner;
  - in IDLE, the lock owner wins regardless of round-robin while its lock stays 1 and the burst counter is below MAX_BURST;
  - the counter increments on each consecutive owner grant while the other master is requesting;
  - it clears when ownership changes, or when the owner is granted with lock=0.
- Lock release:
  - lock clears when the owner is granted with lock=0, or when the owner is idle (req=0) in IDLE;
  - when the counter reaches MAX_BURST with the other master requesting, the other master is granted next; the counter clears and the lock is dropped.
- A single requester is granted regardless of last_grant or lock.
- The rdata registers hold their value until that master's next read completes.

Test Plan:
- Reset, then m0 reads 0x10 (ROM holds 0xA5) -> m0_gnt in cycle +1; mem_address=0x10 for 2 cycles; m0_rvalid in cycle +3 with m0_rdata=0xA5; busy deasserts.
- m1 writes 0x3C to 0x90, then reads 0x90 -> mem_write high for exactly 1 cycle with mem_data_in=0x3C; the read returns 0x3C; wr_err stays 0.
- m0 writes to 0x20, then to 0xE5 -> mem_write stays 0; wr_err pulses once per write; m0_gnt is issued for both writes.
- m0 and m1 continuously request reads with lock=0 -> grants alternate m0, m1, m0, m1 (m0 first after reset).
- m1 holds lock=1 with m0 requesting, MAX_BURST=4 -> exactly 4 consecutive m1 grants, then one m0 grant.
- Reset pulsed during RD2 of an m0 read -> m0_rvalid never asserts; all outputs are 0; the next m1 request is granted normally.
